// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone-style bus arbiter: instruction vs data side, whole cyc-framed grants,
// data preferred with a starvation bound, and a per-beat bus timeout reported as an error.
//
// state   | meaning
// IDLE    | no owner, arbitrate pending cyc requests
// OWN_I   | instruction master owns the bus
// OWN_D   | data master owns the bus
// ERR_I   | instruction cycle timed out, wait for i_cyc to drop
// ERR_D   | data cycle timed out, wait for d_cyc to drop
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cyc,
    input  logic                    i_stb,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_din,
    output logic                    i_ack,
    output logic                    i_err,
    input  logic                    d_cyc,
    input  logic                    d_stb,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_sel,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_dout,
    output logic [DATA_WIDTH-1:0]   d_din,
    output logic                    d_ack,
    output logic                    d_err,
    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    output logic [DATA_WIDTH/8-1:0] m_sel,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_dout,
    input  logic [DATA_WIDTH-1:0]   m_din,
    input  logic                    m_ack,
    input  logic                    m_err,
    output logic [1:0]              grant
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam int TCW = 16;
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
    localparam logic [TCW-1:0] TO_MAX     = TCW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OWN_I = 3'd1,
        S_OWN_D = 3'd2,
        S_ERR_I = 3'd3,
        S_ERR_D = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [SCW-1:0] r_starve_cnt;
    logic [SCW-1:0] w_starve_nxt;
    logic [TCW-1:0] r_to_cnt;
    logic [TCW-1:0] w_to_nxt;
    logic           w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_to_cnt     <= w_to_nxt;
        end
    end

    assign w_timeout = (r_to_cnt == TO_MAX);

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_to_nxt     = '0;
        m_cyc        = 1'b0;
        m_stb        = 1'b0;
        m_we         = 1'b0;
        m_sel        = '0;
        m_addr       = '0;
        m_dout       = '0;
        i_din        = '0;
        i_ack        = 1'b0;
        i_err        = 1'b0;
        d_din        = '0;
        d_ack        = 1'b0;
        d_err        = 1'b0;
        grant        = 2'b00;

        unique case (r_state)
            S_IDLE: begin
                // The increment branch is only reachable below STARVE_MAX, so it saturates.
                if (i_cyc && (!d_cyc || r_starve_cnt == STARVE_MAX)) begin
                    w_state_nxt  = S_OWN_I;
                    w_starve_nxt = '0;
                end else if (d_cyc) begin
                    w_state_nxt  = S_OWN_D;
                    w_starve_nxt = i_cyc ? r_starve_cnt + 1'b1 : '0;
                end else begin
                    w_starve_nxt = '0;
                end
            end

            S_OWN_I: begin
                grant = 2'b01;
                if (w_timeout) begin
                    i_err       = 1'b1;
                    w_state_nxt = i_cyc ? S_ERR_I : S_IDLE;
                end else begin
                    m_cyc  = i_cyc;
                    m_stb  = i_cyc & i_stb;
                    m_sel  = '1;
                    m_addr = i_addr;
                    i_din  = m_din;
                    i_ack  = m_ack;
                    i_err  = m_err;
                    if (i_cyc && i_stb && !m_ack && !m_err) begin
                        w_to_nxt = r_to_cnt + 1'b1;
                    end
                    if (!i_cyc) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_OWN_D: begin
                grant = 2'b10;
                if (w_timeout) begin
                    d_err       = 1'b1;
                    w_state_nxt = d_cyc ? S_ERR_D : S_IDLE;
                end else begin
                    m_cyc  = d_cyc;
                    m_stb  = d_cyc & d_stb;
                    m_we   = d_we;
                    m_sel  = d_sel;
                    m_addr = d_addr;
                    m_dout = d_dout;
                    d_din  = m_din;
                    d_ack  = m_ack;
                    d_err  = m_err;
                    if (d_cyc && d_stb && !m_ack && !m_err) begin
                        w_to_nxt = r_to_cnt + 1'b1;
                    end
                    if (!d_cyc) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            // Late slave responses are swallowed here; the master already saw its error.
            S_ERR_I: begin
                if (!i_cyc) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_ERR_D: begin
                if (!d_cyc) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
